// File: rtl/rf_scoreboard_mp.sv
// Multi-issue integer register file with RAW scoreboard; optional same-cycle write bypass (RF_BYPASS_EN).
// Latency: reads are combinational; writes, busy bits, busy_cnt and wr_conflict update at the next rising edge.
// Backpressure: none; rd_busy gives the issue stage the stall information, this block never refuses a request.
module rf_scoreboard_mp #(
  parameter int XLEN    = 64,
  parameter int NREG    = 32,
  parameter int ISSUE_W = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ISSUE_W*2*$clog2(NREG)-1:0]   rd_addr,
  output logic [ISSUE_W*2*XLEN-1:0]           rd_data,
  output logic [ISSUE_W*2-1:0]                rd_busy,
  input  logic [ISSUE_W-1:0]                  wr_en,
  input  logic [ISSUE_W*$clog2(NREG)-1:0]     wr_addr,
  input  logic [ISSUE_W*XLEN-1:0]             wr_data,
  input  logic [ISSUE_W-1:0]                  iss_en,
  input  logic [ISSUE_W*$clog2(NREG)-1:0]     iss_rd,
  output logic                                wr_conflict,
  output logic [$clog2(NREG):0]               busy_cnt
);

  localparam int AW = $clog2(NREG);
  localparam int NP = ISSUE_W * 2;

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [AW:0]     cnt_nxt;
  logic            conflict_nxt;
  logic [ISSUE_W-1:0] wr_act;

  // A lane really writes only when enabled and not targeting x0.
  always_comb begin
    wr_act = '0;
    for (int l = 0; l < ISSUE_W; l++) begin
      wr_act[l] = wr_en[l] && (wr_addr[l*AW +: AW] != '0);
    end
  end

  // Flag any pair of lanes writing the same nonzero register.
  always_comb begin
    conflict_nxt = 1'b0;
    for (int i = 0; i < ISSUE_W; i++) begin
      for (int j = i + 1; j < ISSUE_W; j++) begin
        if (wr_act[i] && wr_act[j] && (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW])) begin
          conflict_nxt = 1'b1;
        end
      end
    end
  end

  // Scoreboard next state: writebacks release first, then issues reserve, so a
  // producer issued in its predecessor's writeback cycle stays reserved.
  always_comb begin
    busy_nxt = busy;
    for (int l = 0; l < ISSUE_W; l++) begin
      if (wr_act[l]) begin
        busy_nxt[wr_addr[l*AW +: AW]] = 1'b0;
      end
    end
    for (int l = 0; l < ISSUE_W; l++) begin
      if (iss_en[l] && (iss_rd[l*AW +: AW] != '0)) begin
        busy_nxt[iss_rd[l*AW +: AW]] = 1'b1;
      end
    end
  end

  // Popcount of the next busy vector; x0 is never busy so it is skipped.
  always_comb begin
    cnt_nxt = '0;
    for (int r = 1; r < NREG; r++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
    end
  end

  // Register array: lanes are visited in ascending order so the youngest lane's write lands last.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int l = 0; l < ISSUE_W; l++) begin
        if (wr_act[l]) begin
          mem[wr_addr[l*AW +: AW]] <= wr_data[l*XLEN +: XLEN];
        end
      end
    end
  end

  // Scoreboard state, busy count and conflict pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      busy_cnt    <= '0;
      wr_conflict <= 1'b0;
    end else begin
      busy        <= busy_nxt;
      busy_cnt    <= cnt_nxt;
      wr_conflict <= conflict_nxt;
    end
  end

  // Read ports: array value (x0 forced to zero), optionally overridden by a same-cycle write.
  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            hit;
    ra      = '0;
    rdat    = '0;
    hit     = 1'b0;
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NP; p++) begin
      ra   = rd_addr[p*AW +: AW];
      rdat = (ra == '0) ? '0 : mem[ra];
      hit  = 1'b0;
`ifdef RF_BYPASS_EN
      for (int l = 0; l < ISSUE_W; l++) begin
        if (wr_act[l] && (wr_addr[l*AW +: AW] == ra)) begin
          rdat = wr_data[l*XLEN +: XLEN];
          hit  = 1'b1;
        end
      end
`else
      hit = 1'b0;
`endif
      rd_data[p*XLEN +: XLEN] = rdat;
      rd_busy[p]              = busy[ra] & ~hit;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard_mp.sv
// Directed bench for rf_scoreboard_mp (default parameters), valid with or without RF_BYPASS_EN.
// One table row per clock cycle: inputs driven after the edge, outputs checked mid-cycle.
// Registered outputs in a row reflect the previous row's edge.
module tb_rf_scoreboard_mp;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int IW   = 2;
  localparam int AW   = 5;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk;
  logic                  rst;
  logic [IW*2*AW-1:0]    rd_addr;
  logic [IW*2*XLEN-1:0]  rd_data;
  logic [IW*2-1:0]       rd_busy;
  logic [IW-1:0]         wr_en;
  logic [IW*AW-1:0]      wr_addr;
  logic [IW*XLEN-1:0]    wr_data;
  logic [IW-1:0]         iss_en;
  logic [IW*AW-1:0]      iss_rd;
  logic                  wr_conflict;
  logic [AW:0]           busy_cnt;

  rf_scoreboard_mp #(.XLEN(XLEN), .NREG(NREG), .ISSUE_W(IW)) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_rd(iss_rd),
    .wr_conflict(wr_conflict), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   we;
    logic [9:0]   wa;   // {lane1, lane0}
    logic [127:0] wd;
    logic [1:0]   ie;
    logic [9:0]   ia;
    logic [19:0]  ra;   // {p3, p2, p1, p0}
    logic [255:0] ed;
    logic [3:0]   eb;
    logic [5:0]   ecnt;
    logic         econf;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                     input logic [63:0] wd0, input logic [63:0] wd1,
                     input logic [1:0] ie, input logic [4:0] ia0, input logic [4:0] ia1,
                     input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3,
                     input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] d3,
                     input logic [3:0] eb, input logic [5:0] ecnt, input logic econf);
    vec_t v;
    v.we = we;  v.wa = {wa1, wa0};  v.wd = {wd1, wd0};
    v.ie = ie;  v.ia = {ia1, ia0};
    v.ra = {r3, r2, r1, r0};
    v.ed = {d3, d2, d1, d0};
    v.eb = eb;  v.ecnt = ecnt;  v.econf = econf;
    tv.push_back(v);
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = '0; iss_rd = '0;
  endtask

  task automatic apply(input vec_t v, input int i);
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    iss_en = v.ie; iss_rd = v.ia; rd_addr = v.ra;
    #2;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("row%0d_rd_data_p%0d", i, p), rd_data[p*64 +: 64], v.ed[p*64 +: 64]);
      chk($sformatf("row%0d_rd_busy_p%0d", i, p), 64'(rd_busy[p]), 64'(v.eb[p]));
    end
    chk($sformatf("row%0d_busy_cnt", i), 64'(busy_cnt), 64'(v.ecnt));
    chk($sformatf("row%0d_wr_conflict", i), 64'(wr_conflict), 64'(v.econf));
    @(posedge clk); #1;
  endtask

  localparam logic [63:0] Z = 64'h0;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] a5;
    rst = 1'b1; rd_addr = '0; idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset state on every address and every port.
    for (int a = 0; a < NREG; a++) begin
      a5 = a[4:0];
      rd_addr = {a5, a5, a5, a5};
      #1;
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("rst_rd_data_a%0d_p%0d", a, p), rd_data[p*64 +: 64], Z);
        chk($sformatf("rst_rd_busy_a%0d_p%0d", a, p), 64'(rd_busy[p]), Z);
      end
    end
    chk("rst_busy_cnt", 64'(busy_cnt), Z);
    chk("rst_wr_conflict", 64'(wr_conflict), Z);
    @(posedge clk); #1;

    // we   wa0    wa1    wd0          wd1          ie    ia0    ia1    r0     r1     r2     r3     d0..d3                                           eb                       cnt   conf
    add(2'b11, 5'd5, 5'd5, 64'h1234, 64'hABCD, 2'b00, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0,
        BYP ? 64'hABCD : Z, Z, Z, Z, 4'b0000, 6'd0, 1'b0);
    add(2'b00, 5'd0, 5'd0, Z, Z, 2'b00, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0,
        64'hABCD, Z, Z, Z, 4'b0000, 6'd0, 1'b1);
    add(2'b00, 5'd0, 5'd0, Z, Z, 2'b01, 5'd9, 5'd0, 5'd5, 5'd9, 5'd0, 5'd0,
        64'hABCD, Z, Z, Z, 4'b0000, 6'd0, 1'b0);
    add(2'b10, 5'd0, 5'd9, Z, 64'd7, 2'b00, 5'd0, 5'd0, 5'd5, 5'd9, 5'd0, 5'd0,
        64'hABCD, BYP ? 64'd7 : Z, Z, Z, {2'b00, !BYP, 1'b0}, 6'd1, 1'b0);
    add(2'b00, 5'd0, 5'd0, Z, Z, 2'b00, 5'd0, 5'd0, 5'd5, 5'd9, 5'd0, 5'd0,
        64'hABCD, 64'd7, Z, Z, 4'b0000, 6'd0, 1'b0);
    add(2'b01, 5'd3, 5'd0, 64'd1, Z, 2'b10, 5'd0, 5'd3, 5'd0, 5'd9, 5'd3, 5'd0,
        Z, 64'd7, BYP ? 64'd1 : Z, Z, 4'b0000, 6'd0, 1'b0);
    add(2'b01, 5'd0, 5'd0, 64'hFFFF, Z, 2'b10, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0,
        Z, Z, 64'd1, Z, 4'b0100, 6'd1, 1'b0);
    add(2'b11, 5'd0, 5'd0, 64'd1, 64'd2, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0,
        Z, Z, 64'd1, Z, 4'b0100, 6'd1, 1'b0);
    add(2'b00, 5'd0, 5'd0, Z, Z, 2'b11, 5'd12, 5'd12, 5'd0, 5'd0, 5'd3, 5'd12,
        Z, Z, 64'd1, Z, 4'b0100, 6'd1, 1'b0);
    add(2'b00, 5'd0, 5'd0, Z, Z, 2'b01, 5'd12, 5'd0, 5'd0, 5'd0, 5'd3, 5'd12,
        Z, Z, 64'd1, Z, 4'b1100, 6'd2, 1'b0);
    add(2'b11, 5'd12, 5'd20, 64'h55, 64'h77, 2'b00, 5'd0, 5'd0, 5'd0, 5'd20, 5'd3, 5'd12,
        Z, BYP ? 64'h77 : Z, 64'd1, BYP ? 64'h55 : Z, {!BYP, 3'b100}, 6'd2, 1'b0);
    add(2'b00, 5'd0, 5'd0, Z, Z, 2'b00, 5'd0, 5'd0, 5'd0, 5'd20, 5'd3, 5'd12,
        Z, 64'h77, 64'd1, 64'h55, 4'b0100, 6'd1, 1'b0);

    foreach (tv[i]) apply(tv[i], i);

    // Reserve x10/x11, then reset with a write and issues pending in the same cycle.
    idle();
    iss_en = 2'b11; iss_rd = {5'd11, 5'd10};
    @(posedge clk); #1;
    idle();
    rd_addr = {5'd3, 5'd5, 5'd11, 5'd10};
    #1;
    chk("pre_rst_busy_x10", 64'(rd_busy[0]), 64'd1);
    chk("pre_rst_busy_x11", 64'(rd_busy[1]), 64'd1);
    chk("pre_rst_busy_cnt", 64'(busy_cnt), 64'd3);
    rst = 1'b1;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {Z, 64'd5};
    iss_en = 2'b11; iss_rd = {5'd11, 5'd10};
    @(posedge clk); #1;
    rst = 1'b0; idle();
    #1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("post_rst_rd_data_p%0d", p), rd_data[p*64 +: 64], Z);
      chk($sformatf("post_rst_rd_busy_p%0d", p), 64'(rd_busy[p]), Z);
    end
    chk("post_rst_busy_cnt", 64'(busy_cnt), Z);
    chk("post_rst_wr_conflict", 64'(wr_conflict), Z);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard_mp.md
Name: rf_scoreboard_mp

Overview:
- Parametrised multi-issue integer register file for the superscalar RISC-V core; successor to the fixed 2-lane, 64-bit register file.
- Each of ISSUE_W lanes has two read ports and one write port.
- An integrated scoreboard tracks registers with an in-flight producer, so issue logic can stall on RAW hazards.
- Sits between decode/issue (read, reserve) and writeback (write, release).

Parameters:
- XLEN, 64, data width of each register.
- NREG, 32, number of architectural registers. Power of two, ≥ 2.
- ISSUE_W, 2, number of lanes. Lane index order equals program order; the higher index is younger.
- AW, $clog2(NREG), address width. Derived; not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- rd_addr  in  ISSUE_W*2*AW  read addresses. Port p = lane*2 + {0:rs1, 1:rs2}.
- rd_data  out  ISSUE_W*2*XLEN  read data for each port, combinational.
- rd_busy  out  ISSUE_W*2  1 = the addressed register has an unreleased producer.
- wr_en  in  ISSUE_W  per-lane writeback enable.
- wr_addr  in  ISSUE_W*AW  writeback destination.
- wr_data  in  ISSUE_W*XLEN  writeback data.
- iss_en  in  ISSUE_W  per-lane issue; reserves iss_rd.
- iss_rd  in  ISSUE_W*AW  destination being reserved.
- wr_conflict  out  1  registered pulse: two or more lanes wrote the same nonzero address in the previous cycle.
- busy_cnt  out  AW+1  registered count of busy registers.

Behaviour:
- Reset (rst high at posedge):
  - All NREG registers, all busy bits, wr_conflict and busy_cnt go to 0.
  - Reset takes priority over any write or issue in the same cycle.
  - A reset mid-operation discards all pending reservations.
- Register x0:
  - Always reads 0 with rd_busy 0.
  - Writes to x0 are ignored; issue to x0 never sets busy and is never counted.
- Write:
  - On posedge, each lane with wr_en=1 and wr_addr≠0 stores wr_data.
  - Same-address multi-lane write: the highest-index lane wins and wr_conflict=1 on the next cycle; otherwise wr_conflict=0.
- Read, combinational:
  - rd_data[p] = the array value, or the same-cycle bypass value when RF_BYPASS_EN is defined.
  - There is no read latency.
- Scoreboard, one busy bit per register, updated at posedge:
  - Clear busy[r] if any lane writes r this cycle.
  - Then set busy[r] if any lane issues r this cycle. Set wins over clear, so a new producer issued in the writeback cycle stays reserved.
  - Multiple lanes issuing the same r give a single busy bit; no error is raised.
  - Reserving an already-busy register leaves it busy. A single writeback releases it; there is no counting of producers.
- rd_busy[p]:
  - = busy[addr] && !(a same-cycle write to addr), when bypass is enabled.
  - Otherwise = busy[addr].
  - Reflects state before this cycle's issue. Intra-group dependencies are issue logic's responsibility.
- busy_cnt:
  - Registered popcount of busy[NREG-1:1] after the update; range 0..NREG-1.
  - Valid one cycle after the change.
- Writes to non-busy registers are legal and do not alter the scoreboard.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined:
  - A same-cycle write is forwarded to rd_data; the highest-index writing lane wins.
  - rd_busy for that address is suppressed in that cycle.
- Undefined:
  - rd_data shows the stored array only; a write becomes visible the next cycle.
  - rd_busy remains asserted until the cycle after the writeback.
- The bench runs in both configurations.

Test Plan:
- Reset, then read all 32 addresses on all ports -> rd_data all 0, rd_busy all 0, busy_cnt=0, wr_conflict=0.
- Lane0 writes x5=0x1234, lane1 writes x5=0xABCD in the same cycle:
  - Next cycle x5 reads 0xABCD and wr_conflict=1.
  - Cycle after: wr_conflict=0.
  - With RF_BYPASS_EN, a read of x5 in the write cycle returns 0xABCD.
- Issue lane0 to x9:
  - Next cycle rd_busy(x9)=1 and busy_cnt=1.
  - Lane1 writes x9=7: with bypass, rd_busy=0 and rd_data=7 in that cycle; without bypass, the same values appear next cycle. busy_cnt=0 after.
- Same cycle: lane0 write x3=1, lane1 issue x3 -> x3=1 stored, busy(x3) stays 1, busy_cnt=1.
- Write x0=0xFFFF and issue x0 -> reads 0, rd_busy 0, busy_cnt unchanged.
- Issue x10 and x11, then assert rst together with a write of x10=5 -> next cycle all busy bits 0, x10 reads 0, busy_cnt=0.
